regfile_wb_sched: RTL and testbench

//  Writeback scheduler for the 3-port register file (2 read, 1 write).
//  Two writeback sources share the single write port (C) under round-robin arbitration:

---
 rtl/regfile_wb_sched.sv | 97 +++++++++
 tb/tb_regfile_wb_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: round-robin arbitration of ALU and load-unit results onto the
// single register file write port, plus a per-register pending-write scoreboard.
module regfile_wb_sched #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iValid0,
   input  logic [ADDR_W-1:0] iAddr0,
   input  logic [DATA_W-1:0] iData0,
   output logic              oReady0,
   input  logic              iValid1,
   input  logic [ADDR_W-1:0] iAddr1,
   input  logic [DATA_W-1:0] iData1,
   output logic              oReady1,
   input  logic              iIssue,
   input  logic [ADDR_W-1:0] iIssueAddr,
   input  logic [ADDR_W-1:0] iAddrA,
   input  logic [ADDR_W-1:0] iAddrB,
   output logic              oBusyA,
   output logic              oBusyB,
   output logic              oWrite,
   output logic [ADDR_W-1:0] oAddrC,
   output logic [DATA_W-1:0] oRegC
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic             prio_q;
   logic             grant0_c;
   logic             grant1_c;
   logic [DEPTH-1:0] sb_q;
   logic [DEPTH-1:0] sb_d;

   // Round-robin grant; prio_q names the source that wins a tie.
   always_comb begin
      grant0_c = 1'b0;
      grant1_c = 1'b0;
      if (!iRst) begin
         if (iValid0 && (!iValid1 || !prio_q)) begin
            grant0_c = 1'b1;
         end else if (iValid1) begin
            grant1_c = 1'b1;
         end
      end
   end

   assign oReady0 = grant0_c;
   assign oReady1 = grant1_c;

   // Write port: one-cycle latency, r0 writes are swallowed.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         oWrite <= 1'b0;
         oAddrC <= '0;
         oRegC  <= '0;
         prio_q <= 1'b0;
      end else if (grant0_c) begin
         oWrite <= (iAddr0 != '0);
         oAddrC <= iAddr0;
         oRegC  <= iData0;
         prio_q <= 1'b1;
      end else if (grant1_c) begin
         oWrite <= (iAddr1 != '0);
         oAddrC <= iAddr1;
         oRegC  <= iData1;
         prio_q <= 1'b0;
      end else begin
         oWrite <= 1'b0;
      end
   end

   // Scoreboard update: commit clears, issue sets afterwards so a same-edge reissue wins.
   always_comb begin
      sb_d = sb_q;
      if (oWrite) begin
         sb_d[oAddrC] = 1'b0;
      end
      if (iIssue && (iIssueAddr != '0)) begin
         sb_d[iIssueAddr] = 1'b1;
      end
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

   assign oBusyA = sb_q[iAddrA];
   assign oBusyB = sb_q[iAddrB];

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed vector table followed by constrained-random
// traffic checked against a cycle-level reference model.
module tb_regfile_wb_sched;

   localparam int unsigned DW   = 32;
   localparam int unsigned AW   = 5;
   localparam int unsigned NREG = 32;
   localparam int unsigned NRND = 3000;

   logic          iClk = 1'b0;
   logic          iRst;
   logic          iValid0, iValid1, iIssue;
   logic [AW-1:0] iAddr0, iAddr1, iIssueAddr, iAddrA, iAddrB;
   logic [DW-1:0] iData0, iData1;
   logic          oReady0, oReady1, oBusyA, oBusyB, oWrite;
   logic [AW-1:0] oAddrC;
   logic [DW-1:0] oRegC;

   always #5 iClk = ~iClk;

   regfile_wb_sched #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .iClk(iClk), .iRst(iRst),
      .iValid0(iValid0), .iAddr0(iAddr0), .iData0(iData0), .oReady0(oReady0),
      .iValid1(iValid1), .iAddr1(iAddr1), .iData1(iData1), .oReady1(oReady1),
      .iIssue(iIssue), .iIssueAddr(iIssueAddr),
      .iAddrA(iAddrA), .iAddrB(iAddrB), .oBusyA(oBusyA), .oBusyB(oBusyB),
      .oWrite(oWrite), .oAddrC(oAddrC), .oRegC(oRegC)
   );

   typedef struct {
      logic          rst;
      logic          v0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          v1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          iss;
      logic [AW-1:0] ia;
      logic [AW-1:0] aa;
      logic [AW-1:0] ab;
      logic          e_r0;
      logic          e_r1;
      logic          e_ba;
      logic          e_bb;
      logic          e_w;
      logic [AW-1:0] e_ac;
      logic [DW-1:0] e_rc;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: set of pending registers, last winner, and the write port contents.
   bit            m_pend[NREG];
   int            m_last;
   logic          m_w;
   logic [AW-1:0] m_ac;
   logic [DW-1:0] m_rc;

   function automatic vec_t mk(
      input logic rst, input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
      input logic iss, input logic [AW-1:0] ia, input logic [AW-1:0] aa, input logic [AW-1:0] ab,
      input logic r0, input logic r1, input logic ba, input logic bb,
      input logic w, input logic [AW-1:0] ac, input logic [DW-1:0] rc);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
      v.iss = iss; v.ia = ia; v.aa = aa; v.ab = ab;
      v.e_r0 = r0; v.e_r1 = r1; v.e_ba = ba; v.e_bb = bb;
      v.e_w = w; v.e_ac = ac; v.e_rc = rc;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   function automatic int model_grant(input vec_t v);
      if (v.rst) return -1;
      if (v.v0 && v.v1) return (m_last == 0) ? 1 : 0;
      if (v.v0) return 0;
      if (v.v1) return 1;
      return -1;
   endfunction

   task automatic model_edge(input vec_t v, input int win);
      if (v.rst) begin
         foreach (m_pend[i]) m_pend[i] = 1'b0;
         m_last = 1;
         m_w = 1'b0; m_ac = '0; m_rc = '0;
      end else begin
         if (m_w) m_pend[m_ac] = 1'b0;
         if (v.iss && v.ia != 0) m_pend[v.ia] = 1'b1;
         if (win == 0) begin
            m_w = (v.a0 != 0); m_ac = v.a0; m_rc = v.d0; m_last = 0;
         end else if (win == 1) begin
            m_w = (v.a1 != 0); m_ac = v.a1; m_rc = v.d1; m_last = 1;
         end else begin
            m_w = 1'b0;
         end
      end
   endtask

   // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
   task automatic step(input vec_t v, input bit use_tbl, input int idx, output int win);
      iRst = v.rst; iValid0 = v.v0; iAddr0 = v.a0; iData0 = v.d0;
      iValid1 = v.v1; iAddr1 = v.a1; iData1 = v.d1;
      iIssue = v.iss; iIssueAddr = v.ia; iAddrA = v.aa; iAddrB = v.ab;
      #1;
      win = model_grant(v);
      if (use_tbl) begin
         chk("ready0", idx, DW'(oReady0), DW'(v.e_r0));
         chk("ready1", idx, DW'(oReady1), DW'(v.e_r1));
         chk("busyA", idx, DW'(oBusyA), DW'(v.e_ba));
         chk("busyB", idx, DW'(oBusyB), DW'(v.e_bb));
      end else begin
         chk("ready0", idx, DW'(oReady0), DW'(win == 0));
         chk("ready1", idx, DW'(oReady1), DW'(win == 1));
         chk("busyA", idx, DW'(oBusyA), DW'(m_pend[v.aa]));
         chk("busyB", idx, DW'(oBusyB), DW'(m_pend[v.ab]));
      end
      @(posedge iClk);
      model_edge(v, win);
      #1;
      if (use_tbl) begin
         chk("write", idx, DW'(oWrite), DW'(v.e_w));
         chk("addrC", idx, DW'(oAddrC), DW'(v.e_ac));
         chk("regC", idx, oRegC, v.e_rc);
      end else begin
         chk("write", idx, DW'(oWrite), DW'(m_w));
         chk("addrC", idx, DW'(oAddrC), DW'(m_ac));
         chk("regC", idx, oRegC, m_rc);
      end
   endtask

   vec_t tbl[$];

   initial begin
      vec_t v;
      vec_t p0;
      vec_t p1;
      int   win;
      bit   hold0;
      bit   hold1;

      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_last = 1; m_w = 1'b0; m_ac = '0; m_rc = '0;

      // rst v0 a0 d0 | v1 a1 d1 | iss ia aa ab | r0 r1 bA bB | w ac rc
      tbl.push_back(mk(1,1,5'd4,32'hAA,        1,5'd6,32'hBB,        1,5'd4,5'd4,5'd6, 0,0,0,0, 0,5'd0,32'h0));
      tbl.push_back(mk(1,1,5'd4,32'hAA,        1,5'd6,32'hBB,        1,5'd4,5'd4,5'd6, 0,0,0,0, 0,5'd0,32'h0));
      tbl.push_back(mk(0,1,5'd3,32'hDEADBEEF,  0,5'd0,32'h0,         0,5'd0,5'd3,5'd0, 1,0,0,0, 1,5'd3,32'hDEADBEEF));
      tbl.push_back(mk(0,0,5'd0,32'h0,         0,5'd0,32'h0,         0,5'd0,5'd3,5'd0, 0,0,0,0, 0,5'd3,32'hDEADBEEF));
      tbl.push_back(mk(0,0,5'd0,32'h0,         1,5'd9,32'h99,        0,5'd0,5'd9,5'd0, 0,1,0,0, 1,5'd9,32'h99));
      tbl.push_back(mk(0,1,5'd1,32'h11111111,  1,5'd2,32'h22222222,  0,5'd0,5'd1,5'd2, 1,0,0,0, 1,5'd1,32'h11111111));
      tbl.push_back(mk(0,1,5'd1,32'h11111111,  1,5'd2,32'h22222222,  0,5'd0,5'd1,5'd2, 0,1,0,0, 1,5'd2,32'h22222222));
      tbl.push_back(mk(0,1,5'd1,32'h11111111,  1,5'd2,32'h22222222,  0,5'd0,5'd1,5'd2, 1,0,0,0, 1,5'd1,32'h11111111));
      tbl.push_back(mk(0,1,5'd1,32'h11111111,  1,5'd2,32'h22222222,  0,5'd0,5'd1,5'd2, 0,1,0,0, 1,5'd2,32'h22222222));
      tbl.push_back(mk(0,0,5'd0,32'h0,         0,5'd0,32'h0,         1,5'd5,5'd5,5'd0, 0,0,0,0, 0,5'd2,32'h22222222));
      tbl.push_back(mk(0,0,5'd0,32'h0,         0,5'd0,32'h0,         0,5'd0,5'd5,5'd0, 0,0,1,0, 0,5'd2,32'h22222222));
      tbl.push_back(mk(0,1,5'd5,32'h55,        0,5'd0,32'h0,         0,5'd0,5'd5,5'd0, 1,0,1,0, 1,5'd5,32'h55));
      tbl.push_back(mk(0,0,5'd0,32'h0,         0,5'd0,32'h0,         0,5'd0,5'd5,5'd0, 0,0,1,0, 0,5'd5,32'h55));
      tbl.push_back(mk(0,0,5'd0,32'h0,         0,5'd0,32'h0,         0,5'd0,5'd5,5'd0, 0,0,0,0, 0,5'd5,32'h55));
      tbl.push_back(mk(0,0,5'd0,32'h0,         0,5'd0,32'h0,         1,5'd5,5'd5,5'd0, 0,0,0,0, 0,5'd5,32'h55));
      tbl.push_back(mk(0,1,5'd5,32'h56,        0,5'd0,32'h0,         0,5'd0,5'd5,5'd0, 1,0,1,0, 1,5'd5,32'h56));
      tbl.push_back(mk(0,0,5'd0,32'h0,         0,5'd0,32'h0,         1,5'd5,5'd5,5'd0, 0,0,1,0, 0,5'd5,32'h56));
      tbl.push_back(mk(0,0,5'd0,32'h0,         0,5'd0,32'h0,         0,5'd0,5'd5,5'd5, 0,0,1,1, 0,5'd5,32'h56));
      tbl.push_back(mk(0,0,5'd0,32'h0,         1,5'd0,32'h1234,      1,5'd0,5'd0,5'd5, 0,1,0,1, 0,5'd0,32'h1234));
      tbl.push_back(mk(0,0,5'd0,32'h0,         0,5'd0,32'h0,         0,5'd0,5'd0,5'd5, 0,0,0,1, 0,5'd0,32'h1234));
      tbl.push_back(mk(1,1,5'd7,32'h77,        0,5'd0,32'h0,         1,5'd7,5'd7,5'd5, 0,0,0,1, 0,5'd0,32'h0));
      tbl.push_back(mk(0,0,5'd0,32'h0,         0,5'd0,32'h0,         0,5'd0,5'd7,5'd5, 0,0,0,0, 0,5'd0,32'h0));

      // Unchecked bring-up reset so the table starts from a known state.
      iRst = 1'b1; iValid0 = 1'b0; iValid1 = 1'b0; iIssue = 1'b0;
      iAddr0 = '0; iAddr1 = '0; iData0 = '0; iData1 = '0;
      iIssueAddr = '0; iAddrA = '0; iAddrB = '0;
      @(posedge iClk);
      #1;

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i], 1'b1, i, win);
      end

      // Random traffic; a source refused last cycle keeps its request stable.
      p0 = tbl[0]; p0.v0 = 1'b0;
      p1 = tbl[0]; p1.v1 = 1'b0;
      hold0 = 1'b0; hold1 = 1'b0;
      for (int n = 0; n < NRND; n++) begin
         v = tbl[0];
         v.rst = ($urandom_range(0, 63) == 0);
         if (hold0) begin
            v.v0 = p0.v0; v.a0 = p0.a0; v.d0 = p0.d0;
         end else begin
            v.v0 = ($urandom_range(0, 2) != 0);
            v.a0 = AW'($urandom_range(0, NREG - 1));
            v.d0 = $urandom;
         end
         if (hold1) begin
            v.v1 = p1.v1; v.a1 = p1.a1; v.d1 = p1.d1;
         end else begin
            v.v1 = ($urandom_range(0, 2) != 0);
            v.a1 = AW'($urandom_range(0, NREG - 1));
            v.d1 = $urandom;
         end
         v.iss = ($urandom_range(0, 2) == 0);
         v.ia  = AW'($urandom_range(0, NREG - 1));
         v.aa  = AW'($urandom_range(0, NREG - 1));
         v.ab  = (n % 4 == 0) ? v.ia : AW'($urandom_range(0, NREG - 1));
         step(v, 1'b0, 1000 + n, win);
         hold0 = v.v0 && (win != 0) && !v.rst;
         hold1 = v.v1 && (win != 1) && !v.rst;
         p0 = v;
         p1 = v;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
